// File: rtl/mc8051_mem_resp_if.sv
// Request/response bundle between the mc8051 core and its memory responder,
// plus the SFR bus and external code/xdata bus driven by the responder.
//
// Handshake: the core may present i_mem_req at any time, but it is sampled
// only in a cycle where o_mem_busy=0. A sampled request completes with exactly
// one o_mem_ack pulse, qualified by o_mem_err. On the external side,
// o_ext_req acts as valid and is held with stable address/data until a cycle
// with i_ext_ready=1. i_ext_ready outside o_ext_req has no effect.
interface mc8051_mem_resp_if;
  logic        i_mem_req;
  logic        i_mem_we;
  logic [1:0]  i_mem_space;
  logic [15:0] i_mem_addr;
  logic [7:0]  i_mem_wdata;
  logic        o_mem_busy;
  logic        o_mem_ack;
  logic [7:0]  o_mem_rdata;
  logic        o_mem_err;
  logic [7:0]  o_sfr_addr;
  logic        o_sfr_re;
  logic        o_sfr_we;
  logic [7:0]  o_sfr_wdata;
  logic [7:0]  i_sfr_rdata;
  logic        o_ext_req;
  logic        o_ext_we;
  logic        o_ext_code;
  logic [15:0] o_ext_addr;
  logic [7:0]  o_ext_wdata;
  logic        i_ext_ready;
  logic [7:0]  i_ext_rdata;

  // Responder side
  modport slave (
    input  i_mem_req, i_mem_we, i_mem_space, i_mem_addr, i_mem_wdata,
    output o_mem_busy, o_mem_ack, o_mem_rdata, o_mem_err,
    output o_sfr_addr, o_sfr_re, o_sfr_we, o_sfr_wdata,
    input  i_sfr_rdata,
    output o_ext_req, o_ext_we, o_ext_code, o_ext_addr, o_ext_wdata,
    input  i_ext_ready, i_ext_rdata
  );

  // Core / environment side
  modport master (
    output i_mem_req, i_mem_we, i_mem_space, i_mem_addr, i_mem_wdata,
    input  o_mem_busy, o_mem_ack, o_mem_rdata, o_mem_err,
    input  o_sfr_addr, o_sfr_re, o_sfr_we, o_sfr_wdata,
    output i_sfr_rdata,
    input  o_ext_req, o_ext_we, o_ext_code, o_ext_addr, o_ext_wdata,
    output i_ext_ready, i_ext_rdata
  );
endinterface

// File: rtl/mc8051_mem_resp.sv
// mc8051 memory responder: one request at a time, steered to IRAM, the SFR
// bus or the external bus, with a one-cycle ack and an error flag for code
// writes and external timeouts.
module mc8051_mem_resp #(
  parameter int TIMEOUT = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  mc8051_mem_resp_if.slave       bus,
  output logic [1:0]             o_dbg_state
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOC, ST_EXT, ST_ACK} state_t;

  localparam logic [1:0] SP_DIRECT = 2'd0;
  localparam logic [1:0] SP_CODE   = 2'd2;
  localparam logic [1:0] SP_XDATA  = 2'd3;
  // Last counter value before the wait is abandoned.
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        req_we;
  logic [1:0]  req_space;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic [7:0]  wait_cnt;
  logic [7:0]  rdata_q;
  logic        err_q;
  logic [7:0]  iram [256];

  logic accept;
  logic new_is_ext;
  logic r_illegal;
  logic r_sfr;
  logic ext_timeout;

  // Acceptance and decode: new request decides LOC vs EXT, registered one drives LOC.
  always_comb begin
    accept      = bus.i_mem_req && (state == ST_IDLE || state == ST_ACK);
    new_is_ext  = (bus.i_mem_space == SP_XDATA) ||
                  (bus.i_mem_space == SP_CODE && !bus.i_mem_we);
    r_illegal   = (req_space == SP_CODE) && req_we;
    r_sfr       = (req_space == SP_DIRECT) && req_addr[7];
    ext_timeout = (wait_cnt == TO_LAST);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_ACK: begin
        if (accept) state_nxt = new_is_ext ? ST_EXT : ST_LOC;
        else        state_nxt = ST_IDLE;
      end
      ST_LOC:  state_nxt = ST_ACK;
      ST_EXT:  if (bus.i_ext_ready || ext_timeout) state_nxt = ST_ACK;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, wait counter, read data and error status.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      req_we    <= 1'b0;
      req_space <= 2'd0;
      req_addr  <= 16'd0;
      req_wdata <= 8'd0;
      wait_cnt  <= 8'd0;
      rdata_q   <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        req_we    <= bus.i_mem_we;
        req_space <= bus.i_mem_space;
        req_addr  <= bus.i_mem_addr;
        req_wdata <= bus.i_mem_wdata;
        wait_cnt  <= 8'd0;
      end
      case (state)
        ST_LOC: begin
          err_q <= r_illegal;
          if (!req_we && !r_illegal)
            rdata_q <= r_sfr ? bus.i_sfr_rdata : iram[req_addr[7:0]];
        end
        ST_EXT: begin
          if (bus.i_ext_ready) begin
            err_q <= 1'b0;
            if (!req_we) rdata_q <= bus.i_ext_rdata;
          end else if (ext_timeout) begin
            err_q <= 1'b1;
            if (!req_we) rdata_q <= 8'hFF;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // IRAM write port; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (state == ST_LOC && req_we && !r_illegal && !r_sfr)
      iram[req_addr[7:0]] <= req_wdata;
  end

  // Output decode from state and registered request.
  always_comb begin
    bus.o_mem_busy  = (state == ST_LOC) || (state == ST_EXT);
    bus.o_mem_ack   = (state == ST_ACK);
    bus.o_mem_err   = (state == ST_ACK) && err_q;
    bus.o_mem_rdata = rdata_q;
    bus.o_sfr_addr  = req_addr[7:0];
    bus.o_sfr_re    = (state == ST_LOC) && r_sfr && !req_we;
    bus.o_sfr_we    = (state == ST_LOC) && r_sfr && req_we;
    bus.o_sfr_wdata = req_wdata;
    bus.o_ext_req   = (state == ST_EXT);
    bus.o_ext_we    = req_we;
    bus.o_ext_code  = (req_space == SP_CODE);
    bus.o_ext_addr  = req_addr;
    bus.o_ext_wdata = req_wdata;
    o_dbg_state     = state;
  end

endmodule

// File: tb/tb_mc8051_mem_resp.sv
// Self-checking bench for mc8051_mem_resp: randomized traffic against a
// behavioural memory model (IRAM array, last-read-data register).
module tb_mc8051_mem_resp;
  localparam int TMO = 4;
  localparam logic [1:0] SP_DIRECT   = 2'd0;
  localparam logic [1:0] SP_INDIRECT = 2'd1;
  localparam logic [1:0] SP_CODE     = 2'd2;
  localparam logic [1:0] SP_XDATA    = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;

  logic [7:0] ref_iram [256];
  logic [7:0] ref_rdata;
  logic [7:0] exp_q[$];

  mc8051_mem_resp_if bus();

  mc8051_mem_resp #(.TIMEOUT(TMO)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.i_mem_req   = 1'b0;
    bus.i_mem_we    = 1'b0;
    bus.i_mem_space = 2'd0;
    bus.i_mem_addr  = 16'd0;
    bus.i_mem_wdata = 8'd0;
    bus.i_sfr_rdata = 8'd0;
    bus.i_ext_ready = 1'b0;
    bus.i_ext_rdata = 8'd0;
  endtask

  task automatic set_req(input logic we, input logic [1:0] sp,
                         input logic [15:0] a, input logic [7:0] d);
    bus.i_mem_req   = 1'b1;
    bus.i_mem_we    = we;
    bus.i_mem_space = sp;
    bus.i_mem_addr  = a;
    bus.i_mem_wdata = d;
  endtask

  // Presents a one-cycle request; returns at the falling edge of cycle N+1.
  task automatic send_req(input logic we, input logic [1:0] sp,
                          input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    set_req(we, sp, a, d);
    @(negedge clk);
    bus.i_mem_req = 1'b0;
  endtask

  function automatic logic [55:0] all_outs();
    return {bus.o_mem_busy, bus.o_mem_ack, bus.o_mem_err, bus.o_mem_rdata,
            bus.o_sfr_addr, bus.o_sfr_re, bus.o_sfr_we, bus.o_sfr_wdata,
            bus.o_ext_req, bus.o_ext_we, bus.o_ext_code, bus.o_ext_addr,
            bus.o_ext_wdata};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs() !== 56'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", all_outs());
    end
    set_req(1'b0, SP_XDATA, 16'h1234, 8'h00);
    @(negedge clk);
    checks++;
    if (bus.o_mem_busy !== 1'b0 || bus.o_ext_req !== 1'b0) begin
      errors++; $display("FAIL reset_req_ignored busy=%b ext_req=%b exp=0 0",
                         bus.o_mem_busy, bus.o_ext_req);
    end
    idle_inputs();
    rst = 1'b0;
    ref_rdata = 8'h00;
  endtask

  // Fills all of IRAM with held-request INDIRECT writes: one access per 2 cycles.
  task automatic test_back_to_back();
    logic [7:0] d;
    @(negedge clk);
    d = 8'($urandom);
    ref_iram[0] = d;
    set_req(1'b1, SP_INDIRECT, {8'($urandom), 8'd0}, d);
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      checks++;
      if (bus.o_mem_busy !== 1'b1 || bus.o_mem_ack !== 1'b0 || bus.o_sfr_we !== 1'b0) begin
        errors++; $display("FAIL b2b_loc k=%0d busy=%b ack=%b sfr_we=%b exp=1 0 0",
                           k, bus.o_mem_busy, bus.o_mem_ack, bus.o_sfr_we);
      end
      if (k < 255) begin
        d = 8'($urandom);
        ref_iram[k + 1] = d;
        set_req(1'b1, SP_INDIRECT, {8'($urandom), 8'(k + 1)}, d);
      end else begin
        bus.i_mem_req = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (bus.o_mem_ack !== 1'b1 || bus.o_mem_err !== 1'b0 || bus.o_mem_busy !== 1'b0) begin
        errors++; $display("FAIL b2b_ack k=%0d ack=%b err=%b busy=%b exp=1 0 0",
                           k, bus.o_mem_ack, bus.o_mem_err, bus.o_mem_busy);
      end
    end
    checks++;
    if (bus.o_mem_rdata !== ref_rdata) begin
      errors++; $display("FAIL b2b_rdata_held got=%h exp=%h", bus.o_mem_rdata, ref_rdata);
    end
  endtask

  // Fixed test-plan accesses followed by random DIRECT/INDIRECT traffic.
  task automatic test_local_random();
    logic        we;
    logic [1:0]  sp;
    logic [15:0] a;
    logic [7:0]  d, sv, exp;
    logic        is_sfr;
    for (int i = 0; i < 43; i++) begin
      sv = 8'($urandom);
      case (i)
        0: begin we = 1'b1; sp = SP_DIRECT;   a = 16'h0030; d = 8'h5A; end
        1: begin we = 1'b0; sp = SP_DIRECT;   a = 16'h0030; d = 8'h00; end
        2: begin we = 1'b0; sp = SP_INDIRECT; a = 16'h0090; d = 8'h00; end
        default: begin
          we = 1'($urandom_range(0, 1));
          sp = $urandom_range(0, 1) == 0 ? SP_DIRECT : SP_INDIRECT;
          a  = 16'($urandom);
          d  = 8'($urandom);
        end
      endcase
      is_sfr = (sp == SP_DIRECT) && a[7];
      bus.i_sfr_rdata = sv;
      send_req(we, sp, a, d);
      checks++;
      if (bus.o_mem_busy !== 1'b1 || bus.o_mem_ack !== 1'b0) begin
        errors++; $display("FAIL loc_busy i=%0d busy=%b ack=%b exp=1 0",
                           i, bus.o_mem_busy, bus.o_mem_ack);
      end
      checks++;
      if (bus.o_sfr_re !== (is_sfr && !we) || bus.o_sfr_we !== (is_sfr && we)) begin
        errors++; $display("FAIL loc_sfr_strobes i=%0d re=%b we=%b exp=%b %b",
                           i, bus.o_sfr_re, bus.o_sfr_we, is_sfr && !we, is_sfr && we);
      end
      if (is_sfr) begin
        checks++;
        if (bus.o_sfr_addr !== a[7:0] || (we && bus.o_sfr_wdata !== d)) begin
          errors++; $display("FAIL loc_sfr_bus i=%0d addr=%h wdata=%h exp=%h %h",
                             i, bus.o_sfr_addr, bus.o_sfr_wdata, a[7:0], d);
        end
      end
      if (!we) begin
        exp = is_sfr ? sv : ref_iram[a[7:0]];
        exp_q.push_back(exp);
        ref_rdata = exp;
      end else if (!is_sfr) begin
        ref_iram[a[7:0]] = d;
      end
      @(negedge clk);
      checks++;
      if (bus.o_mem_ack !== 1'b1 || bus.o_mem_err !== 1'b0 || bus.o_sfr_re !== 1'b0) begin
        errors++; $display("FAIL loc_ack i=%0d ack=%b err=%b sfr_re=%b exp=1 0 0",
                           i, bus.o_mem_ack, bus.o_mem_err, bus.o_sfr_re);
      end
      exp = we ? ref_rdata : exp_q.pop_front();
      checks++;
      if (bus.o_mem_rdata !== exp) begin
        errors++; $display("FAIL loc_rdata i=%0d got=%h exp=%h", i, bus.o_mem_rdata, exp);
      end
    end
  endtask

  task automatic test_sfr();
    logic [15:0] a;
    logic [7:0]  sv, d;
    logic        we;
    for (int i = 0; i < 3; i++) begin
      we = (i == 1);
      a  = (i == 0) ? 16'h00E0 : {8'($urandom), 1'b1, 7'($urandom)};
      sv = (i == 0) ? 8'h12 : 8'($urandom);
      d  = 8'($urandom);
      bus.i_sfr_rdata = sv;
      send_req(we, SP_DIRECT, a, d);
      checks++;
      if (bus.o_sfr_re !== !we || bus.o_sfr_we !== we || bus.o_sfr_addr !== a[7:0]) begin
        errors++; $display("FAIL sfr_strobe i=%0d re=%b we=%b addr=%h exp=%b %b %h",
                           i, bus.o_sfr_re, bus.o_sfr_we, bus.o_sfr_addr, !we, we, a[7:0]);
      end
      if (!we) ref_rdata = sv;
      @(negedge clk);
      checks++;
      if (bus.o_sfr_re !== 1'b0 || bus.o_sfr_we !== 1'b0 || bus.o_mem_ack !== 1'b1 ||
          bus.o_mem_rdata !== ref_rdata || bus.o_mem_err !== 1'b0) begin
        errors++; $display("FAIL sfr_ack i=%0d re=%b we=%b ack=%b rdata=%h err=%b exp=0 0 1 %h 0",
                           i, bus.o_sfr_re, bus.o_sfr_we, bus.o_mem_ack,
                           bus.o_mem_rdata, bus.o_mem_err, ref_rdata);
      end
    end
  endtask

  task automatic test_xdata();
    logic        we;
    logic [1:0]  sp;
    logic [15:0] a;
    logic [7:0]  d, rd;
    int          dly;
    // Stray ready while idle
    @(negedge clk);
    bus.i_ext_ready = 1'b1;
    bus.i_ext_rdata = 8'h3C;
    @(negedge clk);
    checks++;
    if (bus.o_mem_busy !== 1'b0 || bus.o_mem_ack !== 1'b0 || bus.o_mem_rdata !== ref_rdata) begin
      errors++; $display("FAIL stray_ready busy=%b ack=%b rdata=%h exp=0 0 %h",
                         bus.o_mem_busy, bus.o_mem_ack, bus.o_mem_rdata, ref_rdata);
    end
    bus.i_ext_ready = 1'b0;
    for (int t = 0; t < 8; t++) begin
      we  = (t < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      sp  = (t == 1 || (!we && $urandom_range(0, 1) == 1)) ? SP_CODE : SP_XDATA;
      a   = (t == 0) ? 16'h1234 : 16'($urandom);
      d   = 8'($urandom);
      rd  = (t == 0) ? 8'hA5 : 8'($urandom);
      dly = (t == 0) ? 3 : $urandom_range(0, TMO - 1);
      send_req(we, sp, a, d);
      checks++;
      if (bus.o_ext_req !== 1'b1 || bus.o_mem_busy !== 1'b1 ||
          bus.o_ext_code !== (sp == SP_CODE) || bus.o_ext_we !== we ||
          bus.o_ext_addr !== a || (we && bus.o_ext_wdata !== d) ||
          bus.o_sfr_re !== 1'b0 || bus.o_sfr_we !== 1'b0) begin
        errors++; $display("FAIL ext_start t=%0d req=%b busy=%b code=%b we=%b addr=%h wdata=%h exp=1 1 %b %b %h %h",
                           t, bus.o_ext_req, bus.o_mem_busy, bus.o_ext_code, bus.o_ext_we,
                           bus.o_ext_addr, bus.o_ext_wdata, sp == SP_CODE, we, a, d);
      end
      for (int c = 0; c < dly; c++) begin
        @(negedge clk);
        checks++;
        if (bus.o_ext_req !== 1'b1 || bus.o_mem_ack !== 1'b0 || bus.o_ext_addr !== a ||
            bus.o_ext_we !== we || (we && bus.o_ext_wdata !== d)) begin
          errors++; $display("FAIL ext_wait t=%0d c=%0d req=%b ack=%b addr=%h exp=1 0 %h",
                             t, c, bus.o_ext_req, bus.o_mem_ack, bus.o_ext_addr, a);
        end
      end
      bus.i_ext_ready = 1'b1;
      bus.i_ext_rdata = rd;
      if (!we) ref_rdata = rd;
      @(negedge clk);
      bus.i_ext_ready = 1'b0;
      checks++;
      if (bus.o_mem_ack !== 1'b1 || bus.o_mem_err !== 1'b0 || bus.o_ext_req !== 1'b0 ||
          bus.o_mem_rdata !== ref_rdata) begin
        errors++; $display("FAIL ext_ack t=%0d ack=%b err=%b req=%b rdata=%h exp=1 0 0 %h",
                           t, bus.o_mem_ack, bus.o_mem_err, bus.o_ext_req,
                           bus.o_mem_rdata, ref_rdata);
      end
    end
  endtask

  task automatic test_timeout();
    send_req(1'b0, SP_CODE, 16'($urandom), 8'h00);
    checks++;
    if (bus.o_ext_req !== 1'b1 || bus.o_ext_code !== 1'b1) begin
      errors++; $display("FAIL tmo_start req=%b code=%b exp=1 1", bus.o_ext_req, bus.o_ext_code);
    end
    for (int c = 1; c < TMO; c++) begin
      @(negedge clk);
      checks++;
      if (bus.o_ext_req !== 1'b1 || bus.o_mem_ack !== 1'b0) begin
        errors++; $display("FAIL tmo_wait c=%0d req=%b ack=%b exp=1 0",
                           c, bus.o_ext_req, bus.o_mem_ack);
      end
    end
    @(negedge clk);
    ref_rdata = 8'hFF;
    checks++;
    if (bus.o_mem_ack !== 1'b1 || bus.o_mem_err !== 1'b1 || bus.o_mem_rdata !== 8'hFF ||
        bus.o_ext_req !== 1'b0) begin
      errors++; $display("FAIL tmo_ack ack=%b err=%b rdata=%h req=%b exp=1 1 ff 0",
                         bus.o_mem_ack, bus.o_mem_err, bus.o_mem_rdata, bus.o_ext_req);
    end
    @(negedge clk);
    checks++;
    if (bus.o_mem_ack !== 1'b0 || bus.o_mem_err !== 1'b0 || bus.o_mem_busy !== 1'b0) begin
      errors++; $display("FAIL tmo_after ack=%b err=%b busy=%b exp=0 0 0",
                         bus.o_mem_ack, bus.o_mem_err, bus.o_mem_busy);
    end
  endtask

  task automatic test_illegal_and_drop();
    logic [7:0] x;
    x = 8'($urandom_range(0, 127));
    send_req(1'b1, SP_CODE, 16'($urandom), 8'($urandom));
    // Pulsed while busy: must be dropped
    set_req(1'b1, SP_DIRECT, {8'h00, x}, ~ref_iram[x]);
    checks++;
    if (bus.o_mem_busy !== 1'b1 || bus.o_ext_req !== 1'b0 ||
        bus.o_sfr_re !== 1'b0 || bus.o_sfr_we !== 1'b0) begin
      errors++; $display("FAIL ill_loc busy=%b ext_req=%b sfr_re=%b sfr_we=%b exp=1 0 0 0",
                         bus.o_mem_busy, bus.o_ext_req, bus.o_sfr_re, bus.o_sfr_we);
    end
    @(negedge clk);
    checks++;
    if (bus.o_mem_ack !== 1'b1 || bus.o_mem_err !== 1'b1 || bus.o_mem_rdata !== ref_rdata ||
        bus.o_ext_req !== 1'b0) begin
      errors++; $display("FAIL ill_ack ack=%b err=%b rdata=%h ext_req=%b exp=1 1 %h 0",
                         bus.o_mem_ack, bus.o_mem_err, bus.o_mem_rdata, bus.o_ext_req, ref_rdata);
    end
    // Held through the ack cycle: accepted
    set_req(1'b0, SP_DIRECT, {8'h00, x}, 8'h00);
    @(negedge clk);
    bus.i_mem_req = 1'b0;
    checks++;
    if (bus.o_mem_busy !== 1'b1 || bus.o_mem_ack !== 1'b0) begin
      errors++; $display("FAIL held_loc busy=%b ack=%b exp=1 0", bus.o_mem_busy, bus.o_mem_ack);
    end
    ref_rdata = ref_iram[x];
    @(negedge clk);
    checks++;
    if (bus.o_mem_ack !== 1'b1 || bus.o_mem_err !== 1'b0 || bus.o_mem_rdata !== ref_rdata) begin
      errors++; $display("FAIL held_ack ack=%b err=%b rdata=%h exp=1 0 %h",
                         bus.o_mem_ack, bus.o_mem_err, bus.o_mem_rdata, ref_rdata);
    end
  endtask

  task automatic test_reset_mid_ext();
    logic [7:0] a;
    int         stray_acks;
    send_req(1'b0, SP_XDATA, 16'($urandom), 8'h00);
    @(negedge clk);
    checks++;
    if (bus.o_ext_req !== 1'b1) begin
      errors++; $display("FAIL rst_ext_pre req=%b exp=1", bus.o_ext_req);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_rdata = 8'h00;
    checks++;
    if (bus.o_ext_req !== 1'b0 || bus.o_mem_busy !== 1'b0 || bus.o_mem_ack !== 1'b0 ||
        bus.o_mem_rdata !== 8'h00) begin
      errors++; $display("FAIL rst_ext_post req=%b busy=%b ack=%b rdata=%h exp=0 0 0 00",
                         bus.o_ext_req, bus.o_mem_busy, bus.o_mem_ack, bus.o_mem_rdata);
    end
    stray_acks = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.o_mem_ack !== 1'b0) stray_acks++;
    end
    checks++;
    if (stray_acks != 0) begin
      errors++; $display("FAIL rst_no_ack got=%0d exp=0", stray_acks);
    end
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom);
      send_req(1'b0, SP_INDIRECT, {8'($urandom), a}, 8'h00);
      ref_rdata = ref_iram[a];
      @(negedge clk);
      checks++;
      if (bus.o_mem_ack !== 1'b1 || bus.o_mem_rdata !== ref_rdata) begin
        errors++; $display("FAIL rst_iram_keep addr=%h ack=%b rdata=%h exp=1 %h",
                           a, bus.o_mem_ack, bus.o_mem_rdata, ref_rdata);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_back_to_back();
    test_local_random();
    test_sfr();
    test_xdata();
    test_timeout();
    test_illegal_and_drop();
    test_reset_mid_ext();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
